// File: rtl/issue_unit_pkg.sv
// rtl/issue_unit_pkg.sv - shared widths, tag map, opcode and dispatch-op encodings
package issue_unit_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 16;
    localparam int REG_W  = $clog2(NREG);
    localparam int N_ADD  = 3;
    localparam int N_MUL  = 2;
    localparam int TAG_W  = 3;

    localparam logic [TAG_W-1:0] TAG_NONE     = 3'd0;
    localparam logic [TAG_W-1:0] TAG_ADD_BASE = 3'd1;
    localparam logic [TAG_W-1:0] TAG_MUL_BASE = 3'd4;

    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_SUB = 4'h1;
    localparam logic [3:0] OPC_MUL = 4'h2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } disp_op_e;

endpackage

// File: rtl/issue_unit_reg_status_file.sv
// rtl/issue_unit_reg_status_file.sv - architectural registers plus RAT with two read ports, rename write and CDB snoop
module issue_unit_reg_status_file
    import issue_unit_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  src_a,
    input  logic [REG_W-1:0]  src_b,
    output logic [DATA_W-1:0] val_a,
    output logic [TAG_W-1:0]  tag_a,
    output logic [DATA_W-1:0] val_b,
    output logic [TAG_W-1:0]  tag_b,
    input  logic              ren_en,
    input  logic [REG_W-1:0]  ren_idx,
    input  logic [TAG_W-1:0]  ren_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data
);

    logic [DATA_W-1:0] regs [NREG];
    logic [TAG_W-1:0]  rat  [NREG];

    // A source whose producer is broadcasting this cycle is taken straight off the CDB.
    always_comb begin
        val_a = regs[src_a];
        tag_a = rat[src_a];
        if (rat[src_a] != TAG_NONE) begin
            if (cdb_valid && cdb_tag == rat[src_a]) begin
                val_a = cdb_data;
                tag_a = TAG_NONE;
            end else begin
                val_a = '0;
            end
        end
        val_b = regs[src_b];
        tag_b = rat[src_b];
        if (rat[src_b] != TAG_NONE) begin
            if (cdb_valid && cdb_tag == rat[src_b]) begin
                val_b = cdb_data;
                tag_b = TAG_NONE;
            end else begin
                val_b = '0;
            end
        end
    end

    // The rename write comes after the snoop loop so a new tag on the same rd overrides the clear.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= DATA_W'(i);
                rat[i]  <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (cdb_valid && cdb_tag != TAG_NONE && rat[i] == cdb_tag) begin
                    regs[i] <= cdb_data;
                    rat[i]  <= TAG_NONE;
                end
            end
            if (ren_en) begin
                rat[ren_idx] <= ren_tag;
            end
        end
    end

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - decode, RS entry allocation, stall generation and registered dispatch
module issue_unit
    import issue_unit_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [15:0]       instruction,
    input  logic [N_ADD-1:0]  rs_busy_add,
    input  logic [N_MUL-1:0]  rs_busy_mul,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              stall_bit,
    output logic              disp_valid,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [1:0]        disp_op,
    output logic [DATA_W-1:0] disp_vj,
    output logic [DATA_W-1:0] disp_vk,
    output logic [TAG_W-1:0]  disp_qj,
    output logic [TAG_W-1:0]  disp_qk
);

    logic [3:0]       opcode;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             is_addsub, is_mul, legal;
    logic [N_ADD-1:0] pend_add, free_add;
    logic [N_MUL-1:0] pend_mul, free_mul;
    logic [TAG_W-1:0] alloc_tag;
    logic             class_free, issue;
    disp_op_e         op_next;

    logic [DATA_W-1:0] vj, vk;
    logic [TAG_W-1:0]  qj, qk;

    assign opcode = instruction[15:12];
    assign rs1    = instruction[11:8];
    assign rs2    = instruction[7:4];
    assign rd     = instruction[3:0];

    assign is_addsub = (opcode == OPC_ADD) || (opcode == OPC_SUB);
    assign is_mul    = (opcode == OPC_MUL);
    assign legal     = is_addsub || is_mul;

    // The RS only reports an entry busy a cycle after dispatch, so cover that gap locally.
    always_comb begin
        pend_add = '0;
        pend_mul = '0;
        for (int i = 0; i < N_ADD; i++)
            pend_add[i] = disp_valid && (disp_tag == TAG_ADD_BASE + TAG_W'(i));
        for (int i = 0; i < N_MUL; i++)
            pend_mul[i] = disp_valid && (disp_tag == TAG_MUL_BASE + TAG_W'(i));
    end

    assign free_add = ~(rs_busy_add | pend_add);
    assign free_mul = ~(rs_busy_mul | pend_mul);

    // Scan high to low so the lowest free index is the one left standing.
    always_comb begin
        alloc_tag = TAG_NONE;
        if (is_mul) begin
            for (int i = N_MUL - 1; i >= 0; i--)
                if (free_mul[i]) alloc_tag = TAG_MUL_BASE + TAG_W'(i);
        end else begin
            for (int i = N_ADD - 1; i >= 0; i--)
                if (free_add[i]) alloc_tag = TAG_ADD_BASE + TAG_W'(i);
        end
    end

    assign class_free = (alloc_tag != TAG_NONE);
    assign stall_bit  = inst_valid && legal && !class_free;
    assign issue      = inst_valid && legal && class_free;

    always_comb begin
        op_next = OP_ADD;
        case (opcode)
            OPC_SUB: op_next = OP_SUB;
            OPC_MUL: op_next = OP_MUL;
            default: op_next = OP_ADD;
        endcase
    end

    issue_unit_reg_status_file u_rsf (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .src_a     (rs1),
        .src_b     (rs2),
        .val_a     (vj),
        .tag_a     (qj),
        .val_b     (vk),
        .tag_b     (qk),
        .ren_en    (issue),
        .ren_idx   (rd),
        .ren_tag   (alloc_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_tag   <= TAG_NONE;
            disp_op    <= 2'b00;
            disp_vj    <= '0;
            disp_vk    <= '0;
            disp_qj    <= TAG_NONE;
            disp_qk    <= TAG_NONE;
        end else begin
            disp_valid <= issue;
            if (issue) begin
                disp_tag <= alloc_tag;
                disp_op  <= op_next;
                disp_vj  <= vj;
                disp_vk  <= vk;
                disp_qj  <= qj;
                disp_qk  <= qk;
            end
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - directed and randomized checks of issue_unit against a rename/register model
module tb_issue_unit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] instruction;
    logic [2:0]  rs_busy_add;
    logic [1:0]  rs_busy_mul;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        stall_bit;
    logic        disp_valid;
    logic [2:0]  disp_tag;
    logic [1:0]  disp_op;
    logic [15:0] disp_vj, disp_vk;
    logic [2:0]  disp_qj, disp_qk;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_reg [16];
    logic [2:0]  m_rat [16];
    logic        e_valid;
    logic [2:0]  e_tag;
    logic [1:0]  e_op;
    logic [15:0] e_vj, e_vk;
    logic [2:0]  e_qj, e_qk;

    always #5 clk1 = ~clk1;

    issue_unit dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .rs_busy_add (rs_busy_add),
        .rs_busy_mul (rs_busy_mul),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .stall_bit   (stall_bit),
        .disp_valid  (disp_valid),
        .disp_tag    (disp_tag),
        .disp_op     (disp_op),
        .disp_vj     (disp_vj),
        .disp_vk     (disp_vk),
        .disp_qj     (disp_qj),
        .disp_qk     (disp_qk)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 16'(i);
            m_rat[i] = 3'd0;
        end
        e_valid = 1'b0;
        e_tag = 0; e_op = 0; e_vj = 0; e_vk = 0; e_qj = 0; e_qk = 0;
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0; instruction = 16'h0;
        rs_busy_add = 3'b0; rs_busy_mul = 2'b0;
        cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'h0;
    endtask

    // Drives one instruction cycle starting at a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic [15:0] ins, input logic [2:0] ba, input logic [1:0] bm,
                        input logic cv, input logic [2:0] ct, input logic [15:0] cd);
        logic       taken [6];
        logic [3:0] opc, s1, s2, d;
        logic       legal, is_mul, exp_stall, iss;
        int         lo, hi, pick;
        inst_valid = v; instruction = ins; rs_busy_add = ba; rs_busy_mul = bm;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
        #1;
        opc = ins[15:12]; s1 = ins[11:8]; s2 = ins[7:4]; d = ins[3:0];
        is_mul = (opc == 4'd2);
        legal  = (opc <= 4'd2);
        for (int t = 1; t <= 5; t++)
            taken[t] = ((t <= 3) ? ba[t-1] : bm[t-4]) || (e_valid && e_tag == 3'(t));
        lo = is_mul ? 4 : 1;
        hi = is_mul ? 5 : 3;
        pick = 0;
        for (int t = hi; t >= lo; t--)
            if (!taken[t]) pick = t;
        exp_stall = v && legal && (pick == 0);
        iss = v && legal && (pick != 0);
        total++;
        if (stall_bit !== exp_stall) begin
            bad++;
            $display("FAIL stall_bit ins=%h got=%b exp=%b", ins, stall_bit, exp_stall);
        end
        e_valid = iss;
        if (iss) begin
            e_tag = 3'(pick);
            e_op  = (opc == 4'd0) ? 2'b00 : (opc == 4'd1) ? 2'b01 : 2'b10;
            if (m_rat[s1] == 0) begin e_vj = m_reg[s1]; e_qj = 0; end
            else if (cv && ct == m_rat[s1]) begin e_vj = cd; e_qj = 0; end
            else begin e_vj = 0; e_qj = m_rat[s1]; end
            if (m_rat[s2] == 0) begin e_vk = m_reg[s2]; e_qk = 0; end
            else if (cv && ct == m_rat[s2]) begin e_vk = cd; e_qk = 0; end
            else begin e_vk = 0; e_qk = m_rat[s2]; end
        end
        if (cv && ct != 0)
            for (int r = 0; r < 16; r++)
                if (m_rat[r] == ct) begin m_reg[r] = cd; m_rat[r] = 0; end
        if (iss) m_rat[d] = 3'(pick);
        @(posedge clk1);
        @(negedge clk1);
        total++;
        if (disp_valid !== e_valid) begin
            bad++;
            $display("FAIL disp_valid ins=%h got=%b exp=%b", ins, disp_valid, e_valid);
        end
        if (e_valid) begin
            total++;
            if ({disp_tag, disp_op, disp_vj, disp_vk, disp_qj, disp_qk} !== {e_tag, e_op, e_vj, e_vk, e_qj, e_qk}) begin
                bad++;
                $display("FAIL disp_fields ins=%h got tag=%0d op=%0d vj=%h vk=%h qj=%0d qk=%0d exp tag=%0d op=%0d vj=%h vk=%h qj=%0d qk=%0d",
                         ins, disp_tag, disp_op, disp_vj, disp_vk, disp_qj, disp_qk,
                         e_tag, e_op, e_vj, e_vk, e_qj, e_qk);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        idle_inputs();
        #2;
        model_reset();
        total++;
        if ({disp_valid, disp_tag, disp_op, disp_vj, disp_vk, disp_qj, disp_qk} !== '0) begin
            bad++;
            $display("FAIL reset_disp got valid=%b tag=%0d vj=%h exp all zero", disp_valid, disp_tag, disp_vj);
        end
        total++;
        if (stall_bit !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b exp=0", stall_bit);
        end
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic test_rename_chain();
        step(1, 16'h2123, 3'b000, 2'b00, 0, 0, 0);
        total++;
        if ({disp_tag, disp_op, disp_vj, disp_vk, disp_qj, disp_qk} !== {3'd4, 2'b10, 16'd1, 16'd2, 3'd0, 3'd0}) begin
            bad++;
            $display("FAIL mul_r3 got tag=%0d op=%0d vj=%h vk=%h exp tag=4 op=2 vj=1 vk=2", disp_tag, disp_op, disp_vj, disp_vk);
        end
        step(1, 16'h0345, 3'b000, 2'b01, 0, 0, 0);
        total++;
        if ({disp_tag, disp_vj, disp_qj, disp_vk, disp_qk} !== {3'd1, 16'd0, 3'd4, 16'd4, 3'd0}) begin
            bad++;
            $display("FAIL add_r5 got tag=%0d vj=%h qj=%0d vk=%h exp tag=1 vj=0 qj=4 vk=4", disp_tag, disp_vj, disp_qj, disp_vk);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        step(1, 16'h2123, 3'b000, 2'b00, 0, 0, 0);
        total++;
        if (disp_tag !== 3'd4) begin bad++; $display("FAIL b2b_first got=%0d exp=4", disp_tag); end
        step(1, 16'h2456, 3'b000, 2'b00, 0, 0, 0);
        total++;
        if (disp_tag !== 3'd5) begin bad++; $display("FAIL b2b_second got=%0d exp=5", disp_tag); end
        step(1, 16'h2789, 3'b000, 2'b11, 0, 0, 0);
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL full_no_disp got=%b exp=0", disp_valid); end
        step(1, 16'h2789, 3'b000, 2'b10, 0, 0, 0);
        total++;
        if (disp_tag !== 3'd4) begin bad++; $display("FAIL freed_tag got=%0d exp=4", disp_tag); end
    endtask

    task automatic test_cdb_bypass();
        test_reset();
        step(1, 16'h2123, 3'b000, 2'b00, 0, 0, 0);
        step(1, 16'h0345, 3'b000, 2'b01, 1, 3'd4, 16'h0002);
        total++;
        if ({disp_vj, disp_qj} !== {16'h0002, 3'd0}) begin
            bad++;
            $display("FAIL bypass got vj=%h qj=%0d exp vj=0002 qj=0", disp_vj, disp_qj);
        end
        step(1, 16'h0367, 3'b000, 2'b00, 0, 0, 0);
        total++;
        if ({disp_vj, disp_qj} !== {16'h0002, 3'd0}) begin
            bad++;
            $display("FAIL writeback_r3 got vj=%h qj=%0d exp vj=0002 qj=0", disp_vj, disp_qj);
        end
    endtask

    task automatic test_cdb_vs_rename();
        test_reset();
        step(1, 16'h0125, 3'b000, 2'b00, 0, 0, 0);
        step(1, 16'h0015, 3'b001, 2'b00, 1, 3'd1, 16'h00AA);
        total++;
        if (disp_tag !== 3'd2) begin bad++; $display("FAIL rename_tag got=%0d exp=2", disp_tag); end
        step(1, 16'h0506, 3'b011, 2'b00, 0, 0, 0);
        total++;
        if ({disp_qj, disp_vk} !== {3'd2, 16'd0}) begin
            bad++;
            $display("FAIL new_tag_wins got qj=%0d vk=%h exp qj=2 vk=0", disp_qj, disp_vk);
        end
    endtask

    task automatic test_nop_and_midreset();
        step(1, 16'hF123, 3'b111, 2'b11, 0, 0, 0);
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL nop_disp got=%b exp=0", disp_valid); end
        step(1, 16'h2123, 3'b000, 2'b00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL midreset_disp got=%b exp=0", disp_valid); end
        model_reset();
        idle_inputs();
        @(negedge clk1);
        rst_n = 1'b1;
        step(1, 16'h0345, 3'b000, 2'b00, 0, 0, 0);
        total++;
        if ({disp_tag, disp_vj, disp_qj, disp_vk} !== {3'd1, 16'd3, 3'd0, 16'd4}) begin
            bad++;
            $display("FAIL after_reset got tag=%0d vj=%h qj=%0d vk=%h exp tag=1 vj=3 qj=0 vk=4", disp_tag, disp_vj, disp_qj, disp_vk);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        test_reset();
        for (int n = 0; n < 400; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 7) != 0) ins[15:12] = 4'($urandom_range(0, 2));
            step(($urandom_range(0, 4) != 0), ins, 3'($urandom), 2'($urandom),
                 ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 5)), 16'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_rename_chain();
        test_back_to_back();
        test_cdb_bypass();
        test_cdb_vs_rename();
        test_nop_and_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
